// File: rtl/uart_axis_tx.sv
// uart_axis_tx: AXI-stream fed 8N1 UART transmitter with a small input FIFO.
// The FIFO drains straight into the shift register so frames go out back to back.
module uart_axis_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_BITS   = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic [CLK_BITS-1:0]                clk_per_bit,
  output logic                               uart_tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int CW = CLK_BITS + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CLK_BITS-1:0] period_q, period_d, p_cur, p_new;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic tx_q, tx_d;
  logic push, pop, empty;
  assign empty = level_q == '0;
  assign s_axis_tready = rst_n && level_q != LW'(FIFO_DEPTH);
  assign push = s_axis_tvalid && s_axis_tready;
  // A zero period would never expire; run it as one cycle per bit instead.
  assign p_cur = period_q == '0 ? CLK_BITS'(1) : period_q;
  assign p_new = clk_per_bit == '0 ? CLK_BITS'(1) : clk_per_bit;
  assign uart_tx = tx_q;
  assign busy = state_q != IDLE;
  assign fifo_level = level_q;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    period_d = period_q;
    cnt_d = state_q != IDLE ? cnt_q - CW'(1) : cnt_q;
    bit_d = bit_q;
    tx_d = tx_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_d = mem_q;
    pop = 1'b0;
    case (state_q)
      IDLE: pop = !empty;
      START: if (cnt_q == '0) begin
        state_d = DATA;
        tx_d = shift_q[0];
        shift_d = shift_q >> 1;
        bit_d = '0;
        cnt_d = CW'(p_cur) - CW'(1);
      end
      DATA: if (cnt_q == '0) begin
        if (bit_q == BW'(DATA_WIDTH - 1)) begin
          state_d = STOP;
          tx_d = 1'b1;
          cnt_d = CW'(STOP_BITS) * CW'(p_cur) - CW'(1);
        end else begin
          tx_d = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d = bit_q + BW'(1);
          cnt_d = CW'(p_cur) - CW'(1);
        end
      end
      STOP: if (cnt_q == '0) begin
        state_d = IDLE;
        pop = !empty;
      end
      default: state_d = IDLE;
    endcase
    // Loading the next frame overrides whatever IDLE/STOP chose, giving a gapless start.
    if (pop) begin
      state_d = START;
      shift_d = mem_q[rd_ptr_q];
      period_d = clk_per_bit;
      tx_d = 1'b0;
      cnt_d = CW'(p_new) - CW'(1);
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = s_axis_tdata;
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    level_d = level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      shift_q <= '0;
      period_q <= '0;
      cnt_q <= '0;
      bit_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      shift_q <= shift_d;
      period_q <= period_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: doc/uart_axis_tx.md
# uart_axis_tx

Serial UART transmitter for the TinyTapeout TCP design: accepts bytes on an AXI-stream slave port, buffers them in a small FIFO, and serializes them 8N1-style onto the `uart_tx` pin. Bit period is a run-time input (`clk_per_bit`), sized the same way the UART bridge sizes it. The block is the pin-driving outbound path, the counterpart of the receive deserializer. `tt_um_tcp_top` instantiates it between the core's outbound AXI stream and the physical TX pin.

## Interface
- `DATA_WIDTH`, 8: data bits per frame and `s_axis_tdata` width.
- `CLK_BITS`, 9: width of `clk_per_bit`, equal to $clog2(CLK_FREQ/BAUD_RATE).
- `FIFO_DEPTH`, 4: entries in the input FIFO; power of two, at least 2.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.

- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `s_axis_tdata`  in  DATA_WIDTH: byte to send.
- `s_axis_tvalid`  in  1: upstream has a byte.
- `s_axis_tready`  out  1: FIFO can accept a byte.
- `clk_per_bit`  in  CLK_BITS: clock cycles per UART bit.
- `uart_tx`  out  1: serial line; idles high.
- `busy`  out  1: a frame is in progress (FSM not IDLE).
- `fifo_level`  out  $clog2(FIFO_DEPTH+1): number of occupied FIFO entries.

## Operation
- **Accept (push):** a push occurs when `s_axis_tvalid && s_axis_tready`.
  - `s_axis_tready = !full`, registered-free from `fifo_level`.
  - `s_axis_tready` is held 0 while `rst_n` is low.
- **FIFO:** circular buffer with wrap-around pointers.
  - A push and a pop in the same cycle are legal when not full; `fifo_level` is unchanged.
  - When full there is no push, so a pop in that cycle frees the slot for the next cycle.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty: pop the head into the shift register, latch `clk_per_bit` into `period`, drive `uart_tx`=0.
  - START → DATA after `period` cycles: drive bit 0.
  - DATA: shift LSB first. After DATA_WIDTH bits, each lasting `period` cycles, go to STOP with `uart_tx`=1.
  - STOP: lasts STOP_BITS×`period` cycles. Then:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- **Bit counter:** counts `period`-1 down to 0 and reloads on each bit boundary.
  - A latched `period` of 0 is treated as 1.
  - Changes to `clk_per_bit` take effect only at the next frame start.
- **Outputs:** `uart_tx` comes directly from a flop, never glitching. `busy`=1 in every state except IDLE.
- **Reset (any time, including mid-frame):**
  - Next edge sets `uart_tx`=1, `busy`=0, `fifo_level`=0, `s_axis_tready`=0.
  - The FIFO is flushed and the FSM returns to IDLE.
  - `s_axis_tready`=1 on the first cycle after `rst_n` goes high.

## Timing
- **Push into an empty FIFO with the FSM idle:** byte is written at edge k; `fifo_level`=1 after edge k.
- **Start bit:** at edge k+1 the FSM pops, `uart_tx` falls and `fifo_level` returns to 0. Latency from accept to start bit is 1 cycle.
- **Frame length:** exactly (1+DATA_WIDTH+STOP_BITS)×P cycles, where P = max(latched `clk_per_bit`, 1). With defaults this is 10P.
- **Bit n** (0 = LSB) is on the line during cycles [k+1+(n+1)P, k+1+(n+2)P).
- **Back-to-back:** the next start bit begins the cycle after the last stop-bit cycle. Continuous throughput is one byte per 10P cycles.
- **Capacity:** the FIFO plus the in-flight shift register holds FIFO_DEPTH+1 bytes. `s_axis_tready` drops the cycle after the FIFO reaches FIFO_DEPTH.

## Test plan
- **Single byte:** `clk_per_bit`=4, push 0x55 → `uart_tx` low for 4 cycles, bits 1,0,1,0,1,0,1,0 for 4 cycles each, high for 4 cycles. `busy` high for 40 cycles, then IDLE.
- **Back-to-back:** push 0xA5 then 0x3C on consecutive cycles, `clk_per_bit`=3 → two 30-cycle frames with no idle cycle between the stop bit and the second start bit. Decoded bytes are 0xA5, 0x3C.
- **Backpressure:** hold `s_axis_tvalid`=1 for 8 bytes 0x01..0x08, `clk_per_bit`=2 → `s_axis_tready` falls after 5 accepted bytes. The line carries 0x01..0x08 in order, no loss or duplication, and `fifo_level` never exceeds 4.
- **Rate change:** change `clk_per_bit` from 4 to 8 mid-frame → current frame completes at 4 cycles/bit; the next frame uses 8 cycles/bit.
- **Reset mid-frame:** assert `rst_n`=0 during bit 3 of 0xF0 with 2 bytes queued → next edge `uart_tx`=1, `busy`=0, `fifo_level`=0. After release no queued byte is sent and `s_axis_tready`=1.
- **Degenerate period:** `clk_per_bit`=0 and =1, push 0x81 → 1 cycle per bit, 10-cycle frame, correct bit order.
